// File: rtl/ws281x_ctrl_param.sv
// rtl/ws281x_ctrl_param.sv - WS281x frame sequencer: RAM fetch, MSB-first bit handshake, latch gap
module ws281x_ctrl_param #(
   parameter int PIX_BITS    = 24,
   parameter int ADDR_WIDTH  = 6,
   parameter int RD_LATENCY  = 1,
   parameter int SYNC_CYCLES = 510
) (
   input  logic                           clk_in,
   input  logic                           rst_n_in,
   input  logic                           start_in,
   input  logic                           mode_in,
   input  logic [ADDR_WIDTH-1:0]          start_addr_in,
   input  logic [ADDR_WIDTH:0]            pix_cnt_in,
   input  logic                           bit_done_in,
   input  logic [PIX_BITS+ADDR_WIDTH-1:0] rd_data_in,
   output logic                           rd_en_out,
   output logic [ADDR_WIDTH-1:0]          rd_addr_out,
   output logic                           bit_rdy_out,
   output logic                           bit_data_out,
   output logic                           busy_out,
   output logic                           done_out
);

   localparam int BI_W = $clog2(PIX_BITS);
   localparam int SC_W = $clog2(SYNC_CYCLES + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_READ = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;
   localparam logic [1:0] ST_SYNC = 2'd3;

   localparam logic [BI_W-1:0] BIT_LAST  = BI_W'(PIX_BITS - 1);
   localparam logic [SC_W-1:0] SYNC_LAST = SC_W'(SYNC_CYCLES - 1);
   localparam logic [2:0]      LAT_LAST  = 3'(RD_LATENCY);

   logic [1:0]            state;
   logic                  mode_q;
   logic [ADDR_WIDTH:0]   cnt_q;
   logic [ADDR_WIDTH:0]   fetched;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [2:0]            lat_cnt;
   logic [PIX_BITS-1:0]   pix_sr;
   logic [BI_W-1:0]       bit_idx;
   logic [SC_W-1:0]       sync_cnt;
   logic                  is_last;
   logic                  first_px;
   logic                  tail;
   logic                  pend;

   logic [ADDR_WIDTH-1:0] next_addr;
   logic [ADDR_WIDTH:0]   fetched_nxt;

   assign next_addr   = rd_data_in[PIX_BITS+ADDR_WIDTH-1:PIX_BITS];
   assign fetched_nxt = fetched + 1'b1;

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state        <= ST_IDLE;
         mode_q       <= 1'b0;
         cnt_q        <= '0;
         fetched      <= '0;
         cur_addr     <= '0;
         lat_cnt      <= '0;
         pix_sr       <= '0;
         bit_idx      <= '0;
         sync_cnt     <= '0;
         is_last      <= 1'b0;
         first_px     <= 1'b0;
         tail         <= 1'b0;
         pend         <= 1'b0;
         rd_en_out    <= 1'b0;
         rd_addr_out  <= '0;
         bit_rdy_out  <= 1'b0;
         bit_data_out <= 1'b0;
         busy_out     <= 1'b0;
         done_out     <= 1'b0;
      end else begin
         rd_en_out   <= 1'b0;
         bit_rdy_out <= 1'b0;
         done_out    <= 1'b0;
         case (state)
            ST_IDLE: begin
               // done_out still high here means this is the done cycle: start is dropped
               if (start_in && !done_out) begin
                  mode_q   <= mode_in;
                  cnt_q    <= pix_cnt_in;
                  fetched  <= '0;
                  pend     <= 1'b0;
                  tail     <= 1'b0;
                  busy_out <= 1'b1;
                  if (mode_in && pix_cnt_in == '0) begin
                     state    <= ST_SYNC;
                     sync_cnt <= SYNC_LAST;
                  end else begin
                     state       <= ST_READ;
                     rd_en_out   <= 1'b1;
                     rd_addr_out <= start_addr_in;
                     cur_addr    <= start_addr_in;
                     lat_cnt     <= '0;
                     first_px    <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               // only a prefetch READ has a bit in flight whose ack must be remembered
               if (bit_done_in && !first_px)
                  pend <= 1'b1;
               if (lat_cnt == LAT_LAST) begin
                  state <= ST_SEND;
                  if (mode_q) begin
                     cur_addr <= cur_addr + 1'b1;
                     fetched  <= fetched_nxt;
                     is_last  <= (fetched_nxt == cnt_q);
                  end else begin
                     cur_addr <= next_addr;
                     is_last  <= (next_addr == '0);
                  end
                  if (first_px) begin
                     first_px     <= 1'b0;
                     bit_rdy_out  <= 1'b1;
                     bit_data_out <= rd_data_in[PIX_BITS-1];
                     pix_sr       <= {rd_data_in[PIX_BITS-2:0], 1'b0};
                     bit_idx      <= BI_W'(1);
                  end else begin
                     pix_sr  <= rd_data_in[PIX_BITS-1:0];
                     bit_idx <= '0;
                  end
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            ST_SEND: begin
               if (bit_done_in || pend) begin
                  pend <= 1'b0;
                  if (tail) begin
                     tail     <= 1'b0;
                     state    <= ST_SYNC;
                     sync_cnt <= '0;
                  end else begin
                     bit_rdy_out  <= 1'b1;
                     bit_data_out <= pix_sr[PIX_BITS-1];
                     pix_sr       <= {pix_sr[PIX_BITS-2:0], 1'b0};
                     if (bit_idx == BIT_LAST) begin
                        if (is_last) begin
                           tail <= 1'b1;
                        end else begin
                           state       <= ST_READ;
                           rd_en_out   <= 1'b1;
                           rd_addr_out <= cur_addr;
                           lat_cnt     <= '0;
                        end
                     end else begin
                        bit_idx <= bit_idx + 1'b1;
                     end
                  end
               end
            end
            default: begin
               if (sync_cnt == SYNC_LAST) begin
                  done_out <= 1'b1;
                  busy_out <= 1'b0;
                  state    <= ST_IDLE;
               end else begin
                  sync_cnt <= sync_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule
